// File: rtl/lsu_mem_stage_pkg.sv
// lsu_pkg: shared constants and types for the load/store memory stage.
//   - funct3 access-size encodings (F3_*)
//   - error cause codes (ERR_*)
//   - FSM state enum
//   - tmo_cnt_w(): width of the bus timeout counter for a given TIMEOUT
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } lsu_state_e;

  // A disabled timeout (0) still needs a 1-bit counter to keep the
  // declarations legal.
  function automatic int tmo_cnt_w(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/lsu_mem_stage_if.sv
// lsu_mem_stage_if: data-memory req/ack bus.
//   master (LSU) drives mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb;
//   slave (memory) drives mem_ack, mem_rdata. mem_rdata is valid with mem_ack.
interface lsu_mem_stage_if #(
  parameter int WIDTH = 32
);
  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [3:0]       mem_wstrb;
  logic             mem_ack;
  logic [WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/lsu_mem_stage_lane_align.sv
// lsu_lane_align: purely combinational byte-lane logic for the LSU.
//   in : funct3, offset (addr[1:0]), is_store, st_data, rdata
//   out: wdata/wstrb  - replicated store data and byte enables
//        ld_data      - selected load lane, sign/zero extended
//        misalign     - access not naturally aligned for its size
//        illegal      - funct3 not a legal encoding for the direction
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic        is_store,
  input  logic [31:0] st_data,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] ld_data,
  output logic        misalign,
  output logic        illegal
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte = rdata[7:0];
    case (offset)
      2'd0: ld_byte = rdata[7:0];
      2'd1: ld_byte = rdata[15:8];
      2'd2: ld_byte = rdata[23:16];
      2'd3: ld_byte = rdata[31:24];
      default: ld_byte = rdata[7:0];
    endcase
    ld_half = offset[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    wdata    = st_data;
    wstrb    = 4'b0000;
    ld_data  = '0;
    misalign = 1'b0;
    illegal  = 1'b0;
    case (funct3)
      F3_B: begin
        wdata   = {4{st_data[7:0]}};
        wstrb   = 4'b0001 << offset;
        ld_data = {{24{ld_byte[7]}}, ld_byte};
      end
      F3_H: begin
        wdata    = {2{st_data[15:0]}};
        wstrb    = 4'b0011 << offset;
        ld_data  = {{16{ld_half[15]}}, ld_half};
        misalign = offset[0];
      end
      F3_W: begin
        wdata    = st_data;
        wstrb    = 4'b1111;
        ld_data  = rdata;
        misalign = |offset;
      end
      F3_BU: begin
        ld_data = {24'd0, ld_byte};
        illegal = is_store;
      end
      F3_HU: begin
        ld_data  = {16'd0, ld_half};
        misalign = offset[0];
        illegal  = is_store;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: load/store stage behind the ALU.
//   clk, rst       - clock, synchronous active-high reset
//   alu_valid/alu_result, ld_en, st_en, funct3, st_data, rd_in - op request
//   ready          - high only in IDLE
//   mem_bus        - req/ack data-memory master port
//   wb_valid/wb_data/wb_rd - load write-back (data/rd hold between loads)
//   st_done        - store completion strobe
//   err_valid/err_code     - error strobe and cause
//
// state | meaning
// IDLE  | waiting for an op, request fields latched on accept
// BUS   | mem_req held until ack or timeout
// RESP  | one-cycle wb_valid or st_done
// ERR   | one-cycle error state; strobe is registered out of it
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_valid,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             ld_en,
  input  logic             st_en,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] st_data,
  input  logic [4:0]       rd_in,
  output logic             ready,
  lsu_mem_stage_if.master  mem_bus,
  output logic             wb_valid,
  output logic [WIDTH-1:0] wb_data,
  output logic [4:0]       wb_rd,
  output logic             st_done,
  output logic             err_valid,
  output logic [1:0]       err_code
);

  localparam int CNT_W = tmo_cnt_w(TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  lsu_state_e       state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] st_data_q, st_data_d;
  logic [WIDTH-1:0] wb_data_q, wb_data_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [4:0]       rd_q, rd_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic             we_q, we_d;
  logic [1:0]       cause_q, cause_d;
  logic [1:0]       err_code_q, err_code_d;
  logic             err_valid_q, err_valid_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;

  logic        in_idle, in_bus, in_resp, accept;
  logic [2:0]  al_funct3;
  logic [1:0]  al_offset;
  logic        al_store;
  logic [31:0] al_wdata, al_ld_data;
  logic [3:0]  al_wstrb;
  logic        al_misalign, al_illegal;

  assign in_idle = (state_q == ST_IDLE);
  assign in_bus  = (state_q == ST_BUS);
  assign in_resp = (state_q == ST_RESP);
  assign accept  = alu_valid & (ld_en | st_en);

  // In IDLE the aligner classifies the incoming op; afterwards it works on
  // the latched copy so the bus outputs stay stable for the whole request.
  assign al_funct3 = in_idle ? funct3         : funct3_q;
  assign al_offset = in_idle ? alu_result[1:0] : addr_q[1:0];
  assign al_store  = in_idle ? st_en          : we_q;

  lsu_lane_align u_align (
    .funct3   (al_funct3),
    .offset   (al_offset),
    .is_store (al_store),
    .st_data  (st_data_q),
    .rdata    (mem_bus.mem_rdata),
    .wdata    (al_wdata),
    .wstrb    (al_wstrb),
    .ld_data  (al_ld_data),
    .misalign (al_misalign),
    .illegal  (al_illegal)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    st_data_d   = st_data_q;
    funct3_d    = funct3_q;
    rd_d        = rd_q;
    we_d        = we_q;
    cause_d     = cause_q;
    tmo_d       = tmo_q;
    wb_data_d   = wb_data_q;
    wb_rd_d     = wb_rd_q;
    err_valid_d = 1'b0;
    err_code_d  = 2'b00;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d    = alu_result;
          st_data_d = st_data;
          funct3_d  = funct3;
          rd_d      = rd_in;
          we_d      = st_en;
          tmo_d     = TMO_LOAD;
          if ((ld_en && st_en) || al_illegal) begin
            cause_d = ERR_ILLEGAL;
            state_d = ST_ERR;
          end else if (al_misalign) begin
            cause_d = ERR_MISALIGN;
            state_d = ST_ERR;
          end else begin
            state_d = ST_BUS;
          end
        end
      end

      ST_BUS: begin
        if (mem_bus.mem_ack) begin
          state_d = ST_RESP;
          if (!we_q) begin
            wb_data_d = al_ld_data;
            wb_rd_d   = rd_q;
          end
        end else if (TIMEOUT > 0) begin
          // Counter was loaded with TIMEOUT-1, so reaching zero without an
          // ack means this is the TIMEOUT-th request cycle.
          if (tmo_q == '0) begin
            cause_d = ERR_TIMEOUT;
            state_d = ST_ERR;
          end else begin
            tmo_d = tmo_q - CNT_W'(1);
          end
        end
      end

      ST_RESP: state_d = ST_IDLE;

      ST_ERR: begin
        err_valid_d = 1'b1;
        err_code_d  = cause_q;
        state_d     = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      st_data_q   <= '0;
      funct3_q    <= '0;
      rd_q        <= '0;
      we_q        <= 1'b0;
      cause_q     <= 2'b00;
      tmo_q       <= '0;
      wb_data_q   <= '0;
      wb_rd_q     <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      st_data_q   <= st_data_d;
      funct3_q    <= funct3_d;
      rd_q        <= rd_d;
      we_q        <= we_d;
      cause_q     <= cause_d;
      tmo_q       <= tmo_d;
      wb_data_q   <= wb_data_d;
      wb_rd_q     <= wb_rd_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
    end
  end

  assign ready = in_idle;

  // Bus fields are forced to zero outside BUS so the idle/reset bus is quiet.
  assign mem_bus.mem_req   = in_bus;
  assign mem_bus.mem_we    = in_bus & we_q;
  assign mem_bus.mem_addr  = in_bus ? {addr_q[WIDTH-1:2], 2'b00} : '0;
  assign mem_bus.mem_wdata = (in_bus && we_q) ? al_wdata : '0;
  assign mem_bus.mem_wstrb = (in_bus && we_q) ? al_wstrb : 4'b0000;

  assign wb_valid  = in_resp & ~we_q;
  assign st_done   = in_resp & we_q;
  assign wb_data   = wb_data_q;
  assign wb_rd     = wb_rd_q;
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Testbench for lsu_mem_stage: directed scenarios plus randomized ops checked
// against an arithmetic reference model of access size, alignment and lanes.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, ld_en, st_en;
  logic [31:0] alu_result, st_data;
  logic [2:0]  funct3;
  logic [4:0]  rd_in;
  logic        ready, wb_valid, st_done, err_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic [1:0]  err_code;

  int n_checks = 0;
  int n_fail   = 0;

  lsu_mem_stage_if #(.WIDTH(32)) mem_bus ();

  lsu_mem_stage #(.WIDTH(32), .TIMEOUT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_result (alu_result),
    .ld_en      (ld_en),
    .st_en      (st_en),
    .funct3     (funct3),
    .st_data    (st_data),
    .rd_in      (rd_in),
    .ready      (ready),
    .mem_bus    (mem_bus),
    .wb_valid   (wb_valid),
    .wb_data    (wb_data),
    .wb_rd      (wb_rd),
    .st_done    (st_done),
    .err_valid  (err_valid),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  // Observations from the last do_op call (cycle 1 = first cycle after accept)
  int          o_req, o_first, o_wb_cnt, o_wb_c, o_st_cnt, o_st_c, o_err_cnt, o_err_c, o_busy;
  logic [31:0] o_addr, o_wdata, o_wb_data;
  logic [3:0]  o_wstrb;
  logic        o_we, o_unstable;
  logic [1:0]  o_code;
  logic [4:0]  o_wb_rd;

  // Reference model: what an op should do, from access size and alignment.
  function automatic void model_op(input bit ld, input bit st, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] sd,
                                   input logic [31:0] rdata, output logic [1:0] code,
                                   output logic [31:0] wdata, output logic [3:0] wstrb,
                                   output logic [31:0] ldv);
    int size, o;
    bit sgn, legal;
    logic [31:0] mask, v;
    o = int'(addr % 4);
    case (f3)
      3'd0: begin size = 1; sgn = 1; end
      3'd1: begin size = 2; sgn = 1; end
      3'd2: begin size = 4; sgn = 0; end
      3'd4: begin size = 1; sgn = 0; end
      3'd5: begin size = 2; sgn = 0; end
      default: begin size = 0; sgn = 0; end
    endcase
    legal = (size != 0) && !(ld && st) && !(st && f3 > 3'd2);
    code = 2'b00;
    if (!legal) code = 2'b10;
    else if (o % size != 0) code = 2'b01;
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
    if (size == 1) wdata = (sd & 32'hFF) * 32'h0101_0101;
    else if (size == 2) wdata = (sd & 32'hFFFF) * 32'h0001_0001;
    else wdata = sd;
    wstrb = st ? 4'(((1 << size) - 1) << o) : 4'b0000;
    v = (rdata >> (8 * o)) & mask;
    if (sgn && size < 4 && v[8 * size - 1]) v = v | ~mask;
    ldv = v;
  endfunction

  // Drives one op and acts as memory; ack_after = req-cycle index of ack (0 = never).
  task automatic do_op(input bit ld, input bit st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sd,
                       input logic [4:0] rd, input int ack_after, input logic [31:0] rdata);
    @(posedge clk); #1;
    alu_valid = 1'b1; ld_en = ld; st_en = st; funct3 = f3;
    alu_result = addr; st_data = sd; rd_in = rd;
    @(posedge clk); #1;
    alu_valid = 1'b0; ld_en = 1'b0; st_en = 1'b0;
    alu_result = $urandom; st_data = $urandom; funct3 = 3'($urandom); rd_in = 5'($urandom);
    o_req = 0; o_first = -1; o_wb_cnt = 0; o_wb_c = -1; o_st_cnt = 0; o_st_c = -1;
    o_err_cnt = 0; o_err_c = -1; o_busy = 0; o_unstable = 1'b0;
    o_addr = 'x; o_wdata = 'x; o_wstrb = 'x; o_we = 1'bx; o_code = 2'b00;
    o_wb_data = 'x; o_wb_rd = 'x;
    for (int c = 1; c <= 14; c++) begin
      mem_bus.mem_ack = mem_bus.mem_req && (o_req + 1 == ack_after);
      mem_bus.mem_rdata = mem_bus.mem_ack ? rdata : $urandom;
      @(negedge clk);
      if (!ready) o_busy++;
      if (mem_bus.mem_req) begin
        o_req++;
        if (o_req == 1) begin
          o_first = c; o_addr = mem_bus.mem_addr; o_wdata = mem_bus.mem_wdata;
          o_wstrb = mem_bus.mem_wstrb; o_we = mem_bus.mem_we;
        end else if (o_addr !== mem_bus.mem_addr || o_wdata !== mem_bus.mem_wdata ||
                     o_wstrb !== mem_bus.mem_wstrb || o_we !== mem_bus.mem_we) begin
          o_unstable = 1'b1;
        end
      end
      if (wb_valid) begin o_wb_cnt++; o_wb_c = c; o_wb_data = wb_data; o_wb_rd = wb_rd; end
      if (st_done) begin o_st_cnt++; o_st_c = c; end
      if (err_valid) begin o_err_cnt++; o_err_c = c; o_code = err_code; end
      @(posedge clk); #1;
      mem_bus.mem_ack = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; alu_valid = 0; ld_en = 0; st_en = 0; funct3 = 0;
    alu_result = 0; st_data = 0; rd_in = 0;
    mem_bus.mem_ack = 0; mem_bus.mem_rdata = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", ready); end
    n_checks++; if (mem_bus.mem_req !== 1'b0 || mem_bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_req got req=%b we=%b exp 0", mem_bus.mem_req, mem_bus.mem_we); end
    n_checks++; if (mem_bus.mem_addr !== 32'd0 || mem_bus.mem_wdata !== 32'd0 || mem_bus.mem_wstrb !== 4'd0) begin n_fail++; $display("FAIL reset_bus got addr=%h wdata=%h wstrb=%b exp 0", mem_bus.mem_addr, mem_bus.mem_wdata, mem_bus.mem_wstrb); end
    n_checks++; if (wb_valid !== 1'b0 || wb_data !== 32'd0 || wb_rd !== 5'd0) begin n_fail++; $display("FAIL reset_wb got v=%b d=%h rd=%0d exp 0", wb_valid, wb_data, wb_rd); end
    n_checks++; if (st_done !== 1'b0 || err_valid !== 1'b0 || err_code !== 2'd0) begin n_fail++; $display("FAIL reset_strobes got st=%b err=%b code=%b exp 0", st_done, err_valid, err_code); end
  endtask

  task automatic test_directed;
    do_op(1, 0, 3'b010, 32'h0000_0104, 32'h0, 5'd7, 3, 32'hDEAD_BEEF);
    n_checks++; if (o_req !== 3 || o_first !== 1) begin n_fail++; $display("FAIL lw_req got cycles=%0d first=%0d exp 3/1", o_req, o_first); end
    n_checks++; if (o_addr !== 32'h104 || o_wstrb !== 4'b0000 || o_we !== 1'b0) begin n_fail++; $display("FAIL lw_bus got addr=%h wstrb=%b we=%b exp 104/0000/0", o_addr, o_wstrb, o_we); end
    n_checks++; if (o_wb_cnt !== 1 || o_wb_c !== 4 || o_wb_data !== 32'hDEAD_BEEF || o_wb_rd !== 5'd7) begin n_fail++; $display("FAIL lw_wb got n=%0d cyc=%0d d=%h rd=%0d exp 1/4/deadbeef/7", o_wb_cnt, o_wb_c, o_wb_data, o_wb_rd); end
    n_checks++; if (o_busy !== 4) begin n_fail++; $display("FAIL lw_ready got busy=%0d exp 4", o_busy); end

    do_op(1, 0, 3'b000, 32'h0000_0103, 32'h0, 5'd3, 1, 32'h80FF_1234);
    n_checks++; if (o_wb_data !== 32'hFFFF_FF80 || o_addr !== 32'h100) begin n_fail++; $display("FAIL lb got d=%h addr=%h exp ffffff80/100", o_wb_data, o_addr); end
    do_op(1, 0, 3'b101, 32'h0000_0102, 32'h0, 5'd4, 2, 32'h80FF_1234);
    n_checks++; if (o_wb_data !== 32'h0000_80FF || o_wb_c !== 3) begin n_fail++; $display("FAIL lhu got d=%h cyc=%0d exp 000080ff/3", o_wb_data, o_wb_c); end

    do_op(0, 1, 3'b000, 32'h0000_0101, 32'h1234_56AB, 5'd9, 2, 32'h0);
    n_checks++; if (o_wdata !== 32'hABAB_ABAB || o_wstrb !== 4'b0010 || o_addr !== 32'h100 || o_we !== 1'b1) begin n_fail++; $display("FAIL sb_bus got wdata=%h wstrb=%b addr=%h we=%b", o_wdata, o_wstrb, o_addr, o_we); end
    n_checks++; if (o_st_cnt !== 1 || o_st_c !== 3 || o_wb_cnt !== 0) begin n_fail++; $display("FAIL sb_done got st=%0d cyc=%0d wb=%0d exp 1/3/0", o_st_cnt, o_st_c, o_wb_cnt); end
    n_checks++; if (wb_data !== 32'h0000_80FF || wb_rd !== 5'd4) begin n_fail++; $display("FAIL wb_hold got d=%h rd=%0d exp 000080ff/4", wb_data, wb_rd); end

    do_op(1, 0, 3'b010, 32'h0000_0102, 32'h0, 5'd1, 1, 32'h0);
    n_checks++; if (o_err_cnt !== 1 || o_err_c !== 2 || o_code !== 2'b01 || o_req !== 0) begin n_fail++; $display("FAIL lw_misalign got n=%0d cyc=%0d code=%b req=%0d exp 1/2/01/0", o_err_cnt, o_err_c, o_code, o_req); end
    do_op(1, 0, 3'b011, 32'h0000_0100, 32'h0, 5'd1, 1, 32'h0);
    n_checks++; if (o_err_cnt !== 1 || o_code !== 2'b10 || o_req !== 0) begin n_fail++; $display("FAIL f3_illegal got n=%0d code=%b req=%0d exp 1/10/0", o_err_cnt, o_code, o_req); end
    do_op(1, 1, 3'b010, 32'h0000_0100, 32'h0, 5'd1, 1, 32'h0);
    n_checks++; if (o_err_cnt !== 1 || o_code !== 2'b10 || o_req !== 0 || o_wb_cnt !== 0 || o_st_cnt !== 0) begin n_fail++; $display("FAIL ld_st_both got n=%0d code=%b req=%0d exp 1/10/0", o_err_cnt, o_code, o_req); end
  endtask

  task automatic test_timeout;
    do_op(0, 1, 3'b010, 32'h0000_0200, 32'hCAFE_F00D, 5'd0, 0, 32'h0);
    n_checks++; if (o_req !== 8 || o_unstable !== 1'b0 || o_wdata !== 32'hCAFE_F00D || o_wstrb !== 4'b1111) begin n_fail++; $display("FAIL timeout_req got cycles=%0d unstable=%b wdata=%h wstrb=%b exp 8/0", o_req, o_unstable, o_wdata, o_wstrb); end
    n_checks++; if (o_err_cnt !== 1 || o_code !== 2'b11 || o_err_c <= 8 || o_st_cnt !== 0) begin n_fail++; $display("FAIL timeout_err got n=%0d code=%b cyc=%0d st=%0d exp 1/11/>8/0", o_err_cnt, o_code, o_err_c, o_st_cnt); end
    do_op(1, 0, 3'b010, 32'h0000_0300, 32'h0, 5'd5, 2, 32'h1357_9BDF);
    n_checks++; if (o_wb_cnt !== 1 || o_wb_data !== 32'h1357_9BDF || o_wb_rd !== 5'd5 || o_err_cnt !== 0) begin n_fail++; $display("FAIL after_timeout got n=%0d d=%h rd=%0d err=%0d", o_wb_cnt, o_wb_data, o_wb_rd, o_err_cnt); end
  endtask

  task automatic test_ignore;
    int bad = 0;
    @(posedge clk); #1;
    alu_valid = 1'b1; ld_en = 0; st_en = 0; funct3 = 3'b010; alu_result = 32'h400;
    repeat (4) begin
      @(negedge clk);
      if (mem_bus.mem_req || !ready || err_valid || wb_valid || st_done) bad++;
      @(posedge clk); #1;
    end
    alu_valid = 1'b0;
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL ignore_no_en got %0d active cycles exp 0", bad); end
  endtask

  task automatic test_back_to_back;
    @(posedge clk); #1;
    alu_valid = 1; ld_en = 1; st_en = 0; funct3 = 3'b010; alu_result = 32'h500; rd_in = 5'd1;
    @(posedge clk); #1;
    alu_valid = 0; ld_en = 0;
    mem_bus.mem_ack = 1; mem_bus.mem_rdata = 32'hA5A5_0001;
    @(negedge clk);
    n_checks++; if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 32'h500) begin n_fail++; $display("FAIL b2b_req_a got req=%b addr=%h exp 1/500", mem_bus.mem_req, mem_bus.mem_addr); end
    @(posedge clk); #1;
    mem_bus.mem_ack = 0;
    @(negedge clk);
    n_checks++; if (wb_valid !== 1'b1 || wb_data !== 32'hA5A5_0001 || ready !== 1'b0) begin n_fail++; $display("FAIL b2b_wb_a got v=%b d=%h ready=%b exp 1/a5a50001/0", wb_valid, wb_data, ready); end
    @(posedge clk); #1;
    alu_valid = 1; ld_en = 1; funct3 = 3'b001; alu_result = 32'h602; rd_in = 5'd2;
    @(negedge clk);
    n_checks++; if (ready !== 1'b1 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_ready got ready=%b wb=%b exp 1/0", ready, wb_valid); end
    @(posedge clk); #1;
    alu_valid = 0; ld_en = 0;
    mem_bus.mem_ack = 1; mem_bus.mem_rdata = 32'hC001_5555;
    @(negedge clk);
    n_checks++; if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 32'h600) begin n_fail++; $display("FAIL b2b_req_b got req=%b addr=%h exp 1/600", mem_bus.mem_req, mem_bus.mem_addr); end
    @(posedge clk); #1;
    mem_bus.mem_ack = 0;
    @(negedge clk);
    n_checks++; if (wb_valid !== 1'b1 || wb_data !== 32'hFFFF_C001 || wb_rd !== 5'd2) begin n_fail++; $display("FAIL b2b_wb_b got v=%b d=%h rd=%0d exp 1/ffffc001/2", wb_valid, wb_data, wb_rd); end
  endtask

  task automatic test_reset_mid;
    int bad = 0;
    @(posedge clk); #1;
    alu_valid = 1; ld_en = 1; st_en = 0; funct3 = 3'b010; alu_result = 32'h700; rd_in = 5'd3;
    @(posedge clk); #1;
    alu_valid = 0; ld_en = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (mem_bus.mem_req !== 1'b0 || ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid got req=%b ready=%b exp 0/1", mem_bus.mem_req, ready); end
    @(posedge clk); #1;
    mem_bus.mem_ack = 1; mem_bus.mem_rdata = 32'h7777_7777;
    repeat (4) begin
      @(negedge clk);
      if (wb_valid || st_done || err_valid || mem_bus.mem_req || !ready) bad++;
      @(posedge clk); #1;
      mem_bus.mem_ack = 0;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rst_late_ack got %0d active cycles exp 0", bad); end
    do_op(1, 0, 3'b010, 32'h0000_0704, 32'h0, 5'd6, 1, 32'h0BAD_CAFE);
    n_checks++; if (o_wb_cnt !== 1 || o_wb_data !== 32'h0BAD_CAFE || o_wb_rd !== 5'd6 || o_addr !== 32'h704) begin n_fail++; $display("FAIL rst_recover got n=%0d d=%h rd=%0d addr=%h", o_wb_cnt, o_wb_data, o_wb_rd, o_addr); end
  endtask

  task automatic test_random;
    bit ld, st, have_ld;
    int r, ackd;
    logic [2:0]  f3;
    logic [31:0] addr, sd, rdata, e_wdata, e_ld, last_ld;
    logic [3:0]  e_wstrb;
    logic [1:0]  e_code;
    logic [4:0]  rd, last_rd;
    have_ld = 0; last_ld = 0; last_rd = 0;
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 15);
      ld = (r < 8) || (r == 15);
      st = (r >= 8);
      f3 = 3'($urandom_range(0, 7));
      addr = $urandom; sd = $urandom; rdata = $urandom; rd = 5'($urandom);
      ackd = $urandom_range(1, 4);
      do_op(ld, st, f3, addr, sd, rd, ackd, rdata);
      model_op(ld, st, f3, addr, sd, rdata, e_code, e_wdata, e_wstrb, e_ld);
      if (e_code != 2'b00) begin
        n_checks++; if (o_err_cnt !== 1 || o_code !== e_code || o_err_c !== 2 || o_req !== 0 || o_wb_cnt !== 0 || o_st_cnt !== 0) begin n_fail++; $display("FAIL rnd_err[%0d] f3=%b a=%h got n=%0d code=%b cyc=%0d req=%0d exp code=%b", i, f3, addr, o_err_cnt, o_code, o_err_c, o_req, e_code); end
      end else begin
        n_checks++; if (o_req !== ackd || o_first !== 1 || o_unstable !== 1'b0 || o_addr !== (addr & ~32'h3) || o_we !== st || o_wstrb !== e_wstrb || o_err_cnt !== 0) begin n_fail++; $display("FAIL rnd_bus[%0d] f3=%b a=%h got req=%0d addr=%h we=%b wstrb=%b exp req=%0d wstrb=%b", i, f3, addr, o_req, o_addr, o_we, o_wstrb, ackd, e_wstrb); end
        if (st) begin
          n_checks++; if (o_wdata !== e_wdata || o_st_cnt !== 1 || o_st_c !== ackd + 1 || o_wb_cnt !== 0) begin n_fail++; $display("FAIL rnd_st[%0d] f3=%b got wdata=%h st=%0d cyc=%0d exp wdata=%h", i, f3, o_wdata, o_st_cnt, o_st_c, e_wdata); end
        end else begin
          n_checks++; if (o_wb_cnt !== 1 || o_wb_c !== ackd + 1 || o_wb_data !== e_ld || o_wb_rd !== rd || o_st_cnt !== 0) begin n_fail++; $display("FAIL rnd_ld[%0d] f3=%b a=%h rdata=%h got d=%h rd=%0d cyc=%0d exp d=%h rd=%0d", i, f3, addr, rdata, o_wb_data, o_wb_rd, o_wb_c, e_ld, rd); end
          have_ld = 1; last_ld = e_ld; last_rd = rd;
        end
      end
      if (have_ld) begin
        n_checks++; if (wb_data !== last_ld || wb_rd !== last_rd) begin n_fail++; $display("FAIL rnd_hold[%0d] got d=%h rd=%0d exp d=%h rd=%0d", i, wb_data, wb_rd, last_ld, last_rd); end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_ignore();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
Load/store stage directly downstream of the ALU. It takes the ALU's registered result (`data_out`, `valid`) as the effective address and runs one data-memory transaction over a req/ack handshake. For stores it aligns the store data and byte strobes. For loads it extracts the addressed lane, sign- or zero-extends it, and presents write-back data for the register file. Misaligned accesses, illegal encodings and bus timeouts are reported as single-cycle error pulses.

Parameters:
- WIDTH, 32: data/address width; only 32 is supported.
- TIMEOUT, 16: maximum cycles `mem_req` is held without `mem_ack`; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- alu_valid  in  1  ALU result valid (ALU `valid`).
- alu_result  in  WIDTH  effective address (ALU `data_out`).
- ld_en  in  1  operation is a load.
- st_en  in  1  operation is a store.
- funct3  in  3  access size/sign field.
- st_data  in  WIDTH  rs2 value for stores.
- rd_in  in  5  destination register.
- ready  out  1  1 only in IDLE; the controller must not pulse ALU `en` while this is 0.
- mem_req  out  1  bus request.
- mem_we  out  1  1 = write.
- mem_addr  out  WIDTH  word-aligned address ({addr[31:2],2'b00}).
- mem_wdata  out  WIDTH  replicated store data.
- mem_wstrb  out  4  byte enables (all 0 for loads).
- mem_ack  in  1  transaction complete; `mem_rdata` is valid in the same cycle.
- mem_rdata  in  WIDTH  read data.
- wb_valid  out  1  one-cycle load write-back strobe.
- wb_data  out  WIDTH  extended load data.
- wb_rd  out  5  destination register.
- st_done  out  1  one-cycle store completion strobe.
- err_valid  out  1  one-cycle error strobe.
- err_code  out  2  error cause: 01 misaligned, 10 illegal, 11 timeout.

Behaviour:
- Reset values: every output is 0 except `ready`=1; FSM in IDLE; timeout counter 0.
- Reset mid-transaction: `mem_req` drops at the next edge; no `wb_valid`, `st_done` or `err_valid` is produced; a late `mem_ack` is ignored.
- Legal encodings:
  - Loads: LB 000, LH 001, LW 010, LBU 100, LHU 101.
  - Stores: SB 000, SH 001, SW 010.
- FSM states: IDLE, BUS, RESP, ERR.
- IDLE, with `alu_valid`=1 and `ld_en` or `st_en` set:
  - latch address, `funct3`, `rd_in`, `st_data` and direction;
  - illegal `funct3`, or `ld_en` and `st_en` both set → ERR, code 10;
  - misaligned access → ERR, code 01. Misaligned means halfword with addr[0]=1, or word with addr[1:0]≠0;
  - otherwise → BUS.
- IDLE, with `alu_valid`=1 and neither enable set: ignored; stays in IDLE.
- BUS:
  - `mem_req`=1 with `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb` held stable throughout.
  - On `mem_ack` → RESP; load data is captured on that edge.
  - If TIMEOUT>0 and TIMEOUT req-cycles pass with no ack → ERR, code 11. `mem_req` is high for exactly TIMEOUT cycles.
- RESP: one cycle. A load asserts `wb_valid` with `wb_data`/`wb_rd`; a store asserts `st_done`. Then → IDLE.
- ERR: one cycle with `err_valid`=1 and `err_code`; no memory transaction is issued. Then → IDLE.
- Latency:
  - `alu_valid` at cycle N gives `mem_req` at N+1 (registered).
  - Ack at cycle M gives `wb_valid`/`st_done` at M+1.
  - Minimum op-to-op spacing is 3 cycles.
- `mem_ack` outside BUS is ignored.
- Store packing, with o = addr[1:0]:
  - SB: wdata = {4{data[7:0]}}, wstrb = 0001<<o.
  - SH: wdata = {2{data[15:0]}}, wstrb = 0011<<o.
  - SW: wdata = data, wstrb = 1111.
- Load unpacking: select byte lane `o`, or halfword lane `o[1]`; sign-extend for LB/LH, zero-extend for LBU/LHU.
- `rd`=0 loads still complete normally with `wb_valid`=1; the register file discards them.
- `wb_data`/`wb_rd` hold their values after the pulse until the next load completes.

Decomposition:
- Package `lsu_pkg`:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - error-code constants: ERR_MISALIGN, ERR_ILLEGAL, ERR_TIMEOUT;
  - FSM state enum;
  - timeout counter width $clog2(TIMEOUT+1).
- Sub-module `lsu_lane_align`, purely combinational:
  - store: (`funct3`, `o`, `st_data`) → `wdata`/`wstrb`;
  - load: (`funct3`, `o`, `rdata`) → extended data;
  - misalign/illegal flags.

Test Plan:
1. LW at 0x0000_0104, ack after 3 req-cycles with rdata 0xDEAD_BEEF, rd=7 → `mem_req` high 3 cycles, `mem_addr`=0x104, `wstrb`=0000; next cycle `wb_valid`=1, `wb_data`=0xDEAD_BEEF, `wb_rd`=7.
2. LB / LHU, both with rdata 0x80FF_1234:
   - LB at 0x103 → `wb_data`=0xFFFF_FF80.
   - LHU at 0x102 → `wb_data`=0x0000_80FF.
3. SB at 0x101 with `st_data` 0x1234_56AB → `mem_wdata`=0xABAB_ABAB, `mem_wstrb`=0010, `mem_addr`=0x100; `st_done` the cycle after ack; `wb_valid` never asserted.
4. Error cases:
   - LW at 0x102 → `err_valid`=1, `err_code`=01 at N+2, `mem_req` never asserted.
   - funct3=011 load → `err_code`=10.
   - `ld_en`=`st_en`=1 → `err_code`=10.
5. TIMEOUT=8, SW with no ack → `mem_req` high exactly 8 cycles, then `err_valid` with code 11; a subsequent op is accepted normally.
6. `rst` asserted during BUS, then `mem_ack` pulsed → `mem_req`=0 after the edge, no `wb_valid`, `ready`=1; a following LW completes correctly.
